// File: rtl/bm_operand_feeder_if.sv
// bm_operand_feeder_if
//   Operand bus between a producer, the feeder FIFO and the consumer stage.
//   Push side:     push_valid, push_a, push_b, push_c, push_d (to feeder), push_ready (from feeder)
//   Consumer side: issue, a_out, b_out, c_out, d_out (from feeder)
//   Modports: slave = the feeder itself, master = the producer/consumer environment.
interface bm_operand_feeder_if #(
  parameter int BITS = 2
);
  logic            push_valid;
  logic [BITS-1:0] push_a;
  logic [BITS-1:0] push_b;
  logic            push_c;
  logic            push_d;
  logic            push_ready;
  logic            issue;
  logic [BITS-1:0] a_out;
  logic [BITS-1:0] b_out;
  logic            c_out;
  logic            d_out;

  modport slave (
    input  push_valid, push_a, push_b, push_c, push_d,
    output push_ready, issue, a_out, b_out, c_out, d_out
  );

  modport master (
    output push_valid, push_a, push_b, push_c, push_d,
    input  push_ready, issue, a_out, b_out, c_out, d_out
  );
endinterface

// File: rtl/bm_operand_feeder.sv
// bm_operand_feeder
//   Small operand FIFO that feeds a consumer stage one registered entry per
//   pop. Idle cycles drive all-zero operands so the consumer takes its c = 0
//   path.
//   Ports:
//     clock, reset_n  single clock, synchronous active-low reset
//     hold            downstream stall; queue contents kept, pushes still accepted
//     flush           discard every queued entry (and any same-cycle push)
//     bus             push handshake in, registered operands + issue out
//     level           current occupancy, 0..DEPTH
//     drop_cnt        saturating count of refused pushes; only present when
//                     BM_FEEDER_DROP_CNT_EN is defined
module bm_operand_feeder #(
  parameter int BITS  = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     hold,
  input  logic                     flush,
  bm_operand_feeder_if.slave       bus,
`ifdef BM_FEEDER_DROP_CNT_EN
  output logic [7:0]               drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 2 * BITS + 2;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [EW-1:0]   mem [DEPTH];
  logic [LW-1:0]   level_nx;
  logic            do_push, do_pop;

  // Readiness depends only on current occupancy, not on a same-cycle pop.
  assign bus.push_ready = reset_n && (level < LW'(DEPTH));

  always_comb begin
    do_push  = bus.push_valid && bus.push_ready && !flush;
    do_pop   = (state == RUN) && !hold && !flush;
    level_nx = level;
    state_nx = IDLE;
    if (flush) begin
      level_nx = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   level_nx = level + LW'(1);
        2'b01:   level_nx = level - LW'(1);
        default: level_nx = level;
      endcase
    end
    // State follows the post-update level, so a fresh push into an empty
    // queue only becomes poppable in the following cycle.
    if (level_nx == '0) state_nx = IDLE;
    else if (hold)      state_nx = PAUSE;
    else                state_nx = RUN;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      level     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      bus.issue <= 1'b0;
      bus.a_out <= '0;
      bus.b_out <= '0;
      bus.c_out <= 1'b0;
      bus.d_out <= 1'b0;
    end else begin
      state <= state_nx;
      level <= level_nx;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        // DEPTH is a power of two, so natural overflow is the modulo wrap.
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      bus.issue <= do_pop;
      if (do_pop) {bus.a_out, bus.b_out, bus.c_out, bus.d_out} <= mem[rd_ptr];
      else        {bus.a_out, bus.b_out, bus.c_out, bus.d_out} <= '0;
    end
  end

  // Storage is not reset; occupancy and pointers alone define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= {bus.push_a, bus.push_b, bus.push_c, bus.push_d};
  end

`ifdef BM_FEEDER_DROP_CNT_EN
  // Flush deliberately leaves this count alone; only reset clears it.
  always_ff @(posedge clock) begin
    if (!reset_n)
      drop_cnt <= 8'd0;
    else if (bus.push_valid && !bus.push_ready && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_bm_operand_feeder.sv
module tb_bm_operand_feeder;
  localparam int BITS  = 2;
  localparam int DEPTH = 4;
  localparam int EW    = 2 * BITS + 2;

  logic clock = 1'b0;
  logic reset_n, hold, flush;
  logic [$clog2(DEPTH):0] level;
`ifdef BM_FEEDER_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  bm_operand_feeder_if #(.BITS(BITS)) bus ();

  bm_operand_feeder #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .hold    (hold),
    .flush   (flush),
    .bus     (bus),
`ifdef BM_FEEDER_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .level   (level)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of entries; a pop happens when the queue held
  // something at the start of the cycle, hold was low at the previous edge
  // and is low now, and there is no flush.
  logic [EW-1:0] q[$];
  logic          hold_prev = 1'b0;
  int            drops = 0;
  logic          exp_issue;
  logic [EW-1:0] exp_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic cyc(input logic rn, input logic pv, input logic [EW-1:0] d,
                     input logic h, input logic f);
    logic exp_ready;
    reset_n = rn; hold = h; flush = f;
    bus.push_valid = pv;
    {bus.push_a, bus.push_b, bus.push_c, bus.push_d} = d;
    #1;
    exp_ready = rn && (q.size() < DEPTH);
    chk("push_ready", 32'(bus.push_ready), 32'(exp_ready));
    exp_issue = 1'b0;
    exp_data  = '0;
    if (!rn) begin
      q.delete();
      drops = 0;
    end else begin
      if (pv && !exp_ready && drops < 255) drops++;
      if (f) q.delete();
      else begin
        if (q.size() > 0 && !hold_prev && !h) begin
          exp_data  = q.pop_front();
          exp_issue = 1'b1;
        end
        if (pv && exp_ready) q.push_back(d);
      end
    end
    hold_prev = h;
    @(posedge clock);
    #1;
    chk("issue", 32'(bus.issue), 32'(exp_issue));
    chk("data", 32'({bus.a_out, bus.b_out, bus.c_out, bus.d_out}), 32'(exp_data));
    chk("level", 32'(level), 32'(q.size()));
`ifdef BM_FEEDER_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(drops));
`endif
  endtask

  function automatic logic [EW-1:0] rnd();
    return EW'($urandom);
  endfunction

  initial begin
    reset_n = 1'b0; hold = 1'b0; flush = 1'b0;
    bus.push_valid = 1'b0;
    {bus.push_a, bus.push_b, bus.push_c, bus.push_d} = '0;

    // Reset state
    cyc(0, 1, rnd(), 0, 0);
    cyc(0, 0, '0, 0, 0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_issue", 32'(bus.issue), 32'd0);

    // Single push: issue two cycles after the push cycle
    cyc(1, 1, {2'b01, 2'b11, 1'b1, 1'b1}, 0, 0);
    chk("lat_no_early_issue", 32'(bus.issue), 32'd0);
    cyc(1, 0, '0, 0, 0);
    chk("lat_issue", 32'(bus.issue), 32'd1);
    chk("lat_a", 32'(bus.a_out), 32'h1);
    chk("lat_b", 32'(bus.b_out), 32'h3);
    chk("lat_c", 32'(bus.c_out), 32'h1);
    chk("lat_d", 32'(bus.d_out), 32'h1);
    cyc(1, 0, '0, 0, 0);
    chk("lat_zero_after", 32'({bus.issue, bus.a_out, bus.b_out, bus.c_out, bus.d_out}), 32'd0);

    // Hold high, offer 5 entries into a 4-deep FIFO
    for (int i = 0; i < 5; i++) cyc(1, 1, rnd(), 1, 0);
    chk("full_level", 32'(level), 32'd4);
    chk("full_ready_low", 32'(bus.push_ready), 32'd0);
`ifdef BM_FEEDER_DROP_CNT_EN
    chk("full_drop", 32'(drop_cnt), 32'd1);
`endif

    // Release hold: four issues in push order, back to empty
    for (int i = 0; i < 6; i++) cyc(1, 0, '0, 0, 0);
    chk("drain_level", 32'(level), 32'd0);

    // Continuous push for 10 cycles: level settles at 1, order kept across wrap
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, rnd(), 0, 0);
      chk("stream_level", 32'(level), 32'd1);
    end
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);

    // Flush with 3 queued plus a simultaneous push
    for (int i = 0; i < 3; i++) cyc(1, 1, rnd(), 1, 0);
    cyc(1, 1, {2'b10, 2'b10, 1'b1, 1'b0}, 0, 1);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_issue", 32'(bus.issue), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, 0, 0);

    // Reset while in RUN with 2 queued
    cyc(1, 1, rnd(), 1, 0);
    cyc(1, 1, rnd(), 1, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_out", 32'({bus.issue, bus.a_out, bus.b_out, bus.c_out, bus.d_out}), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(99) >= 2), ($urandom_range(99) < 70), rnd(),
          ($urandom_range(99) < 30), ($urandom_range(99) < 5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
